// File: rtl/wave_dac_pkg.sv
// Shared types and constants for the waveform DAC SPI output stage.
package wave_dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    localparam int FRAME_BITS  = 24;
    localparam int SHIFT_SLOTS = 2 * FRAME_BITS;
    localparam int GAP_SLOTS   = 2;

    localparam logic [7:0]  CTRL_BYTE = 8'h00;
    localparam logic [15:0] MIDSCALE  = 16'h8000;

    localparam logic [2:0] MODE_COS = 3'b001;
    localparam logic [2:0] MODE_SIN = 3'b010;
    localparam logic [2:0] MODE_TAN = 3'b100;

    // tan has no bounded DAC mapping, so it parks the output at midscale
    function automatic logic [15:0] select_code(
        input logic [2:0]  ena,
        input logic [15:0] word
    );
        if (ena == MODE_COS || ena == MODE_SIN)
            return word;
        return MIDSCALE;
    endfunction

endpackage

// File: rtl/wave_dac_sample_timer.sv
// Programmable sample-rate timer: one tick every sample_div+1 cycles.
module wave_dac_sample_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_div,
    output logic        tick
);

    logic [15:0] tcnt;

    assign tick = (sample_div != 16'd0) && (tcnt == sample_div);

    // a period shortened below tcnt lets the counter wrap at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= 16'd0;
        else if (sample_div == 16'd0 || tick)
            tcnt <= 16'd0;
        else
            tcnt <= tcnt + 16'd1;
    end

endmodule

// File: rtl/wave_dac_spi.sv
// Samples the generator word and shifts it to a 16-bit SPI DAC in 24-bit frames.
// Define WAVE_DAC_OVERRUN_CNT_EN to keep the dropped-sample counter.
module wave_dac_spi
    import wave_dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ena,
    input  logic [31:0] data,
    input  logic [15:0] sample_div,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_MAX = SW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_ONE = SW'(1);
    localparam logic [5:0] SHIFT_LAST = 6'(SHIFT_SLOTS - 1);
    localparam logic [5:0] GAP_LAST   = 6'(GAP_SLOTS - 1);

    logic tick;
    state_t state, state_nxt;
    logic [SW-1:0] slot, slot_nxt;
    logic [5:0] half, half_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic cs_n_nxt, sclk_nxt, mosi_nxt, busy_nxt;
    logic slot_last;
    logic unused_data;

    assign unused_data = ^data[31:16];

    wave_dac_sample_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .sample_div (sample_div),
        .tick       (tick)
    );

    assign slot_last = (slot == SLOT_MAX);

    always_comb begin
        state_nxt = state;
        slot_nxt  = '0;
        half_nxt  = half;
        shreg_nxt = shreg;
        cs_n_nxt  = dac_cs_n;
        sclk_nxt  = dac_sclk;
        mosi_nxt  = dac_mosi;
        if (state != IDLE)
            slot_nxt = slot_last ? '0 : slot + SLOT_ONE;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = LEAD;
                    shreg_nxt = {CTRL_BYTE, select_code(ena, data[15:0])};
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = 1'b0;
                end
            end
            LEAD: begin
                if (slot_last) begin
                    state_nxt = SHIFT;
                    half_nxt  = '0;
                    sclk_nxt  = 1'b1;
                    mosi_nxt  = shreg[FRAME_BITS-1];
                    shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
            SHIFT: begin
                if (slot_last) begin
                    if (half == SHIFT_LAST) begin
                        state_nxt = TRAIL;
                        half_nxt  = '0;
                        sclk_nxt  = 1'b0;
                        mosi_nxt  = 1'b0;
                    end else begin
                        half_nxt = half + 6'd1;
                        // even half-slots are high; leaving one drops sclk
                        if (!half[0]) begin
                            sclk_nxt = 1'b0;
                        end else begin
                            sclk_nxt  = 1'b1;
                            mosi_nxt  = shreg[FRAME_BITS-1];
                            shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
            TRAIL: begin
                if (slot_last) begin
                    state_nxt = GAP;
                    half_nxt  = '0;
                    cs_n_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (slot_last) begin
                    if (half == GAP_LAST)
                        state_nxt = IDLE;
                    else
                        half_nxt = half + 6'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            slot     <= '0;
            half     <= '0;
            shreg    <= '0;
            dac_cs_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_mosi <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            half     <= half_nxt;
            shreg    <= shreg_nxt;
            dac_cs_n <= cs_n_nxt;
            dac_sclk <= sclk_nxt;
            dac_mosi <= mosi_nxt;
            busy     <= busy_nxt;
        end
    end

`ifdef WAVE_DAC_OVERRUN_CNT_EN
    logic [7:0] ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr <= 8'h00;
        else if (tick && busy && ovr != 8'hFF)
            ovr <= ovr + 8'd1;
    end

    assign overrun_cnt = ovr;
`else
    assign overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_wave_dac_spi.sv
// Randomized scoreboard bench for wave_dac_spi.
module tb_wave_dac_spi;

    localparam int CD   = 2;
    localparam int FLEN = 52 * CD;

    typedef struct {
        logic [23:0] frame;
        int          start;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  ena;
    logic [31:0] data;
    logic [15:0] sample_div;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        busy;
    logic [7:0]  overrun_cnt;

    wave_dac_spi #(.CLK_DIV(CD)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .data        (data),
        .sample_div  (sample_div),
        .dac_cs_n    (dac_cs_n),
        .dac_sclk    (dac_sclk),
        .dac_mosi    (dac_mosi),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    int   n = 0;
    int   free_at = 0;
    int   dropped = 0;
    int   started = 0;
    bit   rand_in = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [23:0] ref_frame(input logic [2:0] e, input logic [31:0] d);
        if (e == 3'b001 || e == 3'b010)
            return {8'h00, d[15:0]};
        return 24'h008000;
    endfunction

    // reference: ticks fall every sd+1 edges after reset; a tick starts
    // a frame only once the previous 52-slot frame has fully drained
    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            free_at = 0;
            dropped = 0;
            started = 0;
        end else begin
            if (sample_div != 0 && (n % (int'(sample_div) + 1)) == int'(sample_div)) begin
                if (n >= free_at) begin
                    exp_q.push_back('{frame: ref_frame(ena, data), start: n});
                    free_at = n + FLEN + 1;
                    started++;
                end else begin
                    dropped++;
                end
            end
            n++;
        end
    end

    // monitor: DAC-side capture on sclk falling edges
    bit          in_fr = 0;
    bit          prev_cs = 1;
    bit          prev_sclk = 0;
    logic [23:0] cap;
    int          nbits, blen, start_e, rise_e;
    int          frames_seen = 0;
    int          idle_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_fr = 0;
            prev_cs = 1;
            prev_sclk = 0;
            frames_seen = 0;
        end else begin
            if (prev_cs && !dac_cs_n) begin
                in_fr = 1;
                cap = '0;
                nbits = 0;
                blen = 0;
                start_e = n - 1;
                rise_e = -1;
            end
            if (in_fr) begin
                if (busy) blen++;
                if (!prev_sclk && dac_sclk && rise_e < 0) rise_e = n - 1;
                if (prev_sclk && !dac_sclk && !dac_cs_n) begin
                    cap = {cap[22:0], dac_mosi};
                    nbits++;
                end
                if (!busy) begin
                    exp_t e;
                    in_fr = 0;
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", cap, e.frame);
                        chk("nbits", nbits, 24);
                        chk("start_cycle", start_e, e.start);
                        chk("first_sclk", rise_e, e.start + CD);
                        chk("busy_len", blen, FLEN);
                    end
                end
            end else if (dac_sclk || dac_mosi || busy || !dac_cs_n) begin
                idle_bad++;
            end
            prev_cs = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            if (rand_in) begin
                data = $urandom;
                case ($urandom_range(0, 4))
                    0: ena = 3'b001;
                    1: ena = 3'b010;
                    2: ena = 3'b100;
                    3: ena = 3'b000;
                    default: ena = 3'($urandom);
                endcase
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        sample_div = 0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        idle_bad = 0;
        rst = 0;
    endtask

    task automatic end_phase(input string nm);
        int req;
        sample_div = 0;
        run(FLEN + 20);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        chk({nm, "_frames"}, frames_seen, started);
        chk({nm, "_idle_lines"}, idle_bad, 0);
`ifdef WAVE_DAC_OVERRUN_CNT_EN
        req = (dropped > 255) ? 255 : dropped;
`else
        req = 0;
`endif
        chk({nm, "_overrun"}, overrun_cnt, req);
    endtask

    task automatic phase(input string nm, input int sd, input bit rnd,
                         input int cycles, input logic [2:0] e, input logic [31:0] d);
        do_reset();
        ena = e;
        data = d;
        rand_in = rnd;
        sample_div = 16'(sd);
        run(cycles);
        end_phase(nm);
    endtask

    task automatic mid_reset_phase();
        int k;
        do_reset();
        rand_in = 1;
        sample_div = 16'd199;
        k = 0;
        while (!dac_sclk && k < 400) begin
            run(1);
            k++;
        end
        chk("wait_sclk_timeout", (k < 400), 1);
        run(10);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("rst_cs_n", dac_cs_n, 1);
        chk("rst_sclk", dac_sclk, 0);
        chk("rst_mosi", dac_mosi, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        idle_bad = 0;
        rst = 0;
        run(450);
        end_phase("after_rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        ena = 3'b000;
        data = '0;
        sample_div = 0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", dac_cs_n, 1);
        chk("reset_sclk", dac_sclk, 0);
        chk("reset_mosi", dac_mosi, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun_cnt, 0);
        rst = 0;

        phase("stopped", 0, 0, 1000, 3'b001, 32'h1234_5678);
        chk("stopped_no_frames", frames_seen, 0);
        phase("cos_a5c3", 199, 0, 620, 3'b001, 32'h0000_A5C3);
        phase("tan_mid", 199, 0, 220, 3'b100, 32'h3F80_1234);
        phase("off_mid", 199, 0, 220, 3'b000, 32'h3F80_1234);
        phase("sin_rand", 150, 1, 800, 3'b010, 32'h0);
        phase("overlap50", 50, 1, 520, 3'b001, 32'h0);
        phase("last_gap", 103, 1, 650, 3'b001, 32'h0);
        phase("first_idle", 104, 1, 650, 3'b010, 32'h0);
        mid_reset_phase();
        phase("saturate", 5, 1, 3000, 3'b001, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_dac_spi.md
# wave_dac_spi

Downstream output stage of the trigonometric waveform generator. Samples the generator's `data` word at a programmable rate, selects the 16-bit offset-binary code (midscale for unsupported modes) and shifts it to an external 16-bit SPI DAC as a 24-bit frame. It detects and counts samples lost because a frame was still in flight.

## Interface
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; legal range ≥1.
- `clk`  in  1  system clock; every port is synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  3  mode vector, same encoding as the generator: 001 = cos, 010 = sin, 100 = tan.
- `data`  in  32  generator output word.
- `sample_div`  in  16  sample period minus one, in clk cycles; 0 = sampling stopped.
- `dac_cs_n`  out  1  DAC chip select, active low.
- `dac_sclk`  out  1  SPI clock, CPOL=0.
- `dac_mosi`  out  1  serial data, MSB first.
- `busy`  out  1  high while a frame is in flight, including the gap.
- `overrun_cnt`  out  8  saturating count of dropped samples.

## Operation
- Sample timer: counter `tcnt` counts 0..`sample_div`.
  - `tick` is asserted for one cycle when `tcnt == sample_div` and `sample_div != 0`; `tcnt` then returns to 0.
  - Period is `sample_div`+1 cycles.
  - With `sample_div == 0`, `tcnt` is held at 0 and no ticks are produced.
  - A change to `sample_div` applies at the next compare. If the new value is below `tcnt`, the counter wraps at 16 bits before the next tick.
- On `tick` with `busy == 0`:
  - Latch `code = data[15:0]` if `ena` is 001 or 010, otherwise 16'h8000.
  - Build `frame = {8'h00, code}` and leave IDLE.
- On `tick` with `busy == 1`: the sample is dropped and `overrun_cnt` increments, saturating at 255.
- FSM states, one "slot" = `CLK_DIV` cycles:
  - IDLE: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0.
  - LEAD: 1 slot; `cs_n`=0, `sclk`=0, `mosi`=0.
  - SHIFT: 48 slots alternating high/low.
    - Entering each high slot: `sclk`=1, `mosi` = next frame bit, bit 23 first.
    - Entering each low slot: `sclk`=0, `mosi` held; the DAC samples on this falling edge.
  - TRAIL: 1 slot; `sclk`=0, `cs_n`=0, `mosi`=0.
  - GAP: 2 slots; `cs_n`=1.
  - Then return to IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: `dac_cs_n`=1, `dac_sclk`=0, `dac_mosi`=0, `busy`=0, `overrun_cnt`=0, FSM in IDLE, `tcnt`=0.
- Reset mid-frame aborts the frame immediately, asynchronously.
- All SPI outputs are registered; no combinational path from inputs.
- Frame start:
  - `tick` at cycle T → `dac_cs_n` falls and `busy` rises at T+1.
  - The first `sclk` rise occurs at T+1+`CLK_DIV`.
- Frame length: 52·`CLK_DIV` cycles, counted from `busy` rise to `busy` fall.
- Overrun-free operation requires `sample_div`+1 ≥ 52·`CLK_DIV`+1.
- Simultaneous events:
  - `tick` in the last GAP cycle counts as an overrun.
  - `tick` in the first IDLE cycle starts a new frame.
- `data` and `ena` are sampled only on the tick cycle; changes at any other time have no effect on the frame in flight.

## Configuration
- `WAVE_DAC_OVERRUN_CNT_EN` defined: overrun counter present, behaving as specified above.
- Macro undefined: the counter logic is removed and `overrun_cnt` is tied to 8'h00. Overlapping ticks are still dropped silently.

## Structure
- Package `wave_dac_pkg` holds:
  - FSM state enum (IDLE, LEAD, SHIFT, TRAIL, GAP);
  - `FRAME_BITS`=24;
  - `CTRL_BYTE`=8'h00;
  - `MIDSCALE`=16'h8000;
  - mode constants `MODE_COS`=3'b001, `MODE_SIN`=3'b010, `MODE_TAN`=3'b100.
- One sub-module: `wave_dac_sample_timer`, which takes `sample_div` and produces `tick`.
- The FSM, slot divider and shift register stay in the top module.

## Test plan
- Reset, `sample_div`=0 for 1000 cycles → `cs_n` stays 1, `sclk` stays 0, `busy` stays 0, no frames.
- `CLK_DIV`=2, `sample_div`=199, `ena`=001, `data`=32'h0000_A5C3 → one frame every 200 cycles; DAC-side capture on falling edges = 24'h00A5C3; `busy` high for exactly 104 cycles; `overrun_cnt`=0.
- `ena`=100, `data`=32'h3F80_1234 → captured frame 24'h008000. Repeat with `ena`=000 → 24'h008000.
- `CLK_DIV`=2, `sample_div`=50 for 10 ticks → frames only on ticks arriving while idle; `overrun_cnt` equals the model's dropped-tick count. After 300 dropped ticks → 255 (saturated); tied to 0 with the macro undefined.
- Assert `rst` mid-SHIFT → same cycle: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0. Release, next tick → complete, correct frame.
- Force `tick` on the last GAP cycle → overrun +1, no frame. `tick` on the following IDLE cycle → frame starts next cycle.
